// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with dual writeback, optional bypass and pending scoreboard
module reg_file_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD = 2,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0]   RdAddr,
  output logic [NRD*XLEN-1:0] RdData,
  output logic [NRD-1:0]      RdBusy,
  input  logic              WrEn0,
  input  logic [AW-1:0]     WrAddr0,
  input  logic [XLEN-1:0]   WrData0,
  input  logic              WrEn1,
  input  logic [AW-1:0]     WrAddr1,
  input  logic [XLEN-1:0]   WrData1,
  input  logic              Alloc,
  input  logic [AW-1:0]     AllocAddr
);
  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;
  logic w_we0, w_we1, w_al;
  function automatic logic is_legal(input logic [AW-1:0] a);
    return (int'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
  endfunction
  assign w_we0 = WrEn0 && is_legal(WrAddr0);
  assign w_we1 = WrEn1 && is_legal(WrAddr1);
  assign w_al = Alloc && is_legal(AllocAddr);
  // writes clear pending, a same-cycle alloc re-sets it for the new producer
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_we0) w_pend_nxt[WrAddr0] = 1'b0;
    if (w_we1) w_pend_nxt[WrAddr1] = 1'b0;
    if (w_al) w_pend_nxt[AllocAddr] = 1'b1;
  end
  // register array and scoreboard update; port 1 is written last so it wins a conflict
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NREG; j++) r_regs[j] <= '0;
      r_pend <= '0;
    end else begin
      if (w_we0) r_regs[WrAddr0] <= WrData0;
      if (w_we1) r_regs[WrAddr1] <= WrData1;
      r_pend <= w_pend_nxt;
    end
  end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] w_a;
    logic w_ok, w_b0, w_b1;
    assign w_a = RdAddr[i*AW +: AW];
    assign w_ok = is_legal(w_a);
    assign w_b0 = (BYPASS != 0) && w_we0 && (WrAddr0 == w_a);
    assign w_b1 = (BYPASS != 0) && w_we1 && (WrAddr1 == w_a);
    assign RdData[i*XLEN +: XLEN] = !w_ok ? '0 : w_b1 ? WrData1 : w_b0 ? WrData0 : r_regs[w_a];
    assign RdBusy[i] = w_ok && !w_b0 && !w_b1 && r_pend[w_a];
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed checks of reg_file_mp with bypass on (NREG=32) and off (NREG=24)
module tb_reg_file_mp;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] RdAddr;
  logic [63:0] m_data, n_data;
  logic [1:0] m_busy, n_busy;
  logic WrEn0, WrEn1, Alloc;
  logic [4:0] WrAddr0, WrAddr1, AllocAddr;
  logic [31:0] WrData0, WrData1;
  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  reg_file_mp dut (
    .clk(clk), .rst(rst), .RdAddr(RdAddr), .RdData(m_data), .RdBusy(m_busy),
    .WrEn0(WrEn0), .WrAddr0(WrAddr0), .WrData0(WrData0),
    .WrEn1(WrEn1), .WrAddr1(WrAddr1), .WrData1(WrData1),
    .Alloc(Alloc), .AllocAddr(AllocAddr)
  );

  reg_file_mp #(.NREG(24), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .RdAddr(RdAddr), .RdData(n_data), .RdBusy(n_busy),
    .WrEn0(WrEn0), .WrAddr0(WrAddr0), .WrData0(WrData0),
    .WrEn1(WrEn1), .WrAddr1(WrAddr1), .WrData1(WrData1),
    .Alloc(Alloc), .AllocAddr(AllocAddr)
  );

  task tick;
    @(posedge clk);
    #1;
  endtask

  task idle;
    WrEn0 = 0; WrEn1 = 0; Alloc = 0; rst = 0;
    WrAddr0 = 0; WrAddr1 = 0; AllocAddr = 0; WrData0 = 0; WrData1 = 0;
  endtask

  task test_reset;
    idle(); RdAddr = {5'd12, 5'd5}; rst = 1; tick(); rst = 0; #1;
    ncmp++; if (m_data !== 64'h0 || n_data !== 64'h0) begin nerr++; $display("FAIL reset_data: got %h / %h want 0", m_data, n_data); end
    ncmp++; if (m_busy !== 2'b00 || n_busy !== 2'b00) begin nerr++; $display("FAIL reset_busy: got %b / %b want 00", m_busy, n_busy); end
    WrEn0 = 1; WrAddr0 = 5; WrData0 = 32'hDEADBEEF; tick(); idle(); #1;
    ncmp++; if (n_data[31:0] !== 32'hDEADBEEF) begin nerr++; $display("FAIL pre_reset_r5: got %h want deadbeef", n_data[31:0]); end
    rst = 1; tick(); rst = 0; #1;
    ncmp++; if (m_data[31:0] !== 32'h0 || n_data[31:0] !== 32'h0) begin nerr++; $display("FAIL post_reset_r5: got %h / %h want 0", m_data[31:0], n_data[31:0]); end
    ncmp++; if (m_busy !== 2'b00 || n_busy !== 2'b00) begin nerr++; $display("FAIL post_reset_busy: got %b / %b want 00", m_busy, n_busy); end
  endtask

  task test_conflict;
    idle(); WrEn0 = 1; WrAddr0 = 7; WrData0 = 32'h11111111; WrEn1 = 1; WrAddr1 = 7; WrData1 = 32'h22222222;
    tick(); idle(); RdAddr = {5'd7, 5'd7}; #1;
    ncmp++; if (m_data[31:0] !== 32'h22222222 || n_data[63:32] !== 32'h22222222) begin nerr++; $display("FAIL conflict_r7: got %h / %h want 22222222", m_data[31:0], n_data[63:32]); end
    WrEn0 = 1; WrAddr0 = 3; WrData0 = 32'hAAAA0003; WrEn1 = 1; WrAddr1 = 4; WrData1 = 32'hBBBB0004;
    tick(); idle(); RdAddr = {5'd4, 5'd3}; #1;
    ncmp++; if (m_data !== 64'hBBBB0004_AAAA0003) begin nerr++; $display("FAIL dual_write_main: got %h want bbbb0004aaaa0003", m_data); end
    ncmp++; if (n_data !== 64'hBBBB0004_AAAA0003) begin nerr++; $display("FAIL dual_write_nb: got %h want bbbb0004aaaa0003", n_data); end
  endtask

  task test_bypass;
    idle(); RdAddr = {5'd10, 5'd9}; WrEn0 = 1; WrAddr0 = 9; WrData0 = 32'h0000ABCD; #1;
    ncmp++; if (m_data[31:0] !== 32'h0000ABCD) begin nerr++; $display("FAIL bypass_on: got %h want 0000abcd", m_data[31:0]); end
    ncmp++; if (n_data[31:0] !== 32'h0) begin nerr++; $display("FAIL bypass_off_same: got %h want 0", n_data[31:0]); end
    tick(); idle(); #1;
    ncmp++; if (n_data[31:0] !== 32'h0000ABCD) begin nerr++; $display("FAIL bypass_off_next: got %h want 0000abcd", n_data[31:0]); end
    WrEn0 = 1; WrAddr0 = 10; WrData0 = 32'h1; WrEn1 = 1; WrAddr1 = 10; WrData1 = 32'h2; #1;
    ncmp++; if (m_data[63:32] !== 32'h2) begin nerr++; $display("FAIL bypass_prio: got %h want 2", m_data[63:32]); end
    tick(); idle();
  endtask

  task test_zero;
    idle(); RdAddr = {5'd0, 5'd0}; WrEn0 = 1; WrAddr0 = 0; WrData0 = 32'hFFFFFFFF; Alloc = 1; AllocAddr = 0; #1;
    ncmp++; if (m_data !== 64'h0 || m_busy !== 2'b00) begin nerr++; $display("FAIL zero_same: got %h busy %b want 0 busy 00", m_data, m_busy); end
    tick(); idle(); #1;
    ncmp++; if (m_data !== 64'h0 || n_data !== 64'h0) begin nerr++; $display("FAIL zero_data: got %h / %h want 0", m_data, n_data); end
    ncmp++; if (m_busy !== 2'b00 || n_busy !== 2'b00) begin nerr++; $display("FAIL zero_busy: got %b / %b want 00", m_busy, n_busy); end
  endtask

  task test_scoreboard;
    idle(); RdAddr = {5'd11, 5'd12}; Alloc = 1; AllocAddr = 12; tick(); idle(); #1;
    ncmp++; if (m_busy !== 2'b01 || n_busy !== 2'b01) begin nerr++; $display("FAIL alloc_busy: got %b / %b want 01", m_busy, n_busy); end
    tick();
    ncmp++; if (m_busy !== 2'b01 || n_busy !== 2'b01) begin nerr++; $display("FAIL alloc_hold: got %b / %b want 01", m_busy, n_busy); end
    WrEn1 = 1; WrAddr1 = 12; WrData1 = 32'h5; #1;
    ncmp++; if (m_busy[0] !== 1'b0 || m_data[31:0] !== 32'h5) begin nerr++; $display("FAIL wb_same_on: got busy %b data %h want 0 / 5", m_busy[0], m_data[31:0]); end
    ncmp++; if (n_busy[0] !== 1'b1 || n_data[31:0] !== 32'h0) begin nerr++; $display("FAIL wb_same_off: got busy %b data %h want 1 / 0", n_busy[0], n_data[31:0]); end
    tick(); idle(); #1;
    ncmp++; if (m_busy !== 2'b00 || n_busy !== 2'b00 || n_data[31:0] !== 32'h5) begin nerr++; $display("FAIL wb_next: got %b / %b data %h want 00 / 00 / 5", m_busy, n_busy, n_data[31:0]); end
    Alloc = 1; AllocAddr = 12; WrEn0 = 1; WrAddr0 = 12; WrData0 = 32'h6; #1;
    ncmp++; if (m_busy[0] !== 1'b0 || m_data[31:0] !== 32'h6) begin nerr++; $display("FAIL alloc_wr_same: got busy %b data %h want 0 / 6", m_busy[0], m_data[31:0]); end
    tick(); idle(); #1;
    ncmp++; if (m_busy[0] !== 1'b1 || n_busy[0] !== 1'b1) begin nerr++; $display("FAIL alloc_wr_busy: got %b / %b want 1", m_busy[0], n_busy[0]); end
    ncmp++; if (m_data[31:0] !== 32'h6 || n_data[31:0] !== 32'h6) begin nerr++; $display("FAIL alloc_wr_data: got %h / %h want 6", m_data[31:0], n_data[31:0]); end
    Alloc = 1; AllocAddr = 12; tick(); idle(); #1;
    ncmp++; if (m_busy[0] !== 1'b1) begin nerr++; $display("FAIL realloc: got %b want 1", m_busy[0]); end
    WrEn0 = 1; WrAddr0 = 12; WrData0 = 32'h7; tick(); idle(); #1;
    ncmp++; if (m_busy[0] !== 1'b0 || n_busy[0] !== 1'b0) begin nerr++; $display("FAIL single_clear: got %b / %b want 0", m_busy[0], n_busy[0]); end
  endtask

  task test_range;
    idle(); RdAddr = {5'd6, 5'd30}; WrEn0 = 1; WrAddr0 = 30; WrData0 = 32'h12345678; Alloc = 1; AllocAddr = 30; #1;
    ncmp++; if (m_data[31:0] !== 32'h12345678 || n_data[31:0] !== 32'h0) begin nerr++; $display("FAIL range_same: got %h / %h want 12345678 / 0", m_data[31:0], n_data[31:0]); end
    tick(); idle(); #1;
    ncmp++; if (n_data !== 64'h0 || n_busy !== 2'b00) begin nerr++; $display("FAIL range_nb: got %h busy %b want 0 busy 00", n_data, n_busy); end
    ncmp++; if (m_data[31:0] !== 32'h12345678 || m_busy[0] !== 1'b1) begin nerr++; $display("FAIL range_main: got %h busy %b want 12345678 busy 1", m_data[31:0], m_busy[0]); end
  endtask

  task test_mid_reset;
    idle(); RdAddr = {5'd30, 5'd2}; Alloc = 1; AllocAddr = 2; tick(); idle(); #1;
    ncmp++; if (m_busy !== 2'b11) begin nerr++; $display("FAIL mid_pre_busy: got %b want 11", m_busy); end
    rst = 1; WrEn0 = 1; WrAddr0 = 2; WrData0 = 32'h7; Alloc = 1; AllocAddr = 2; tick(); idle(); #1;
    ncmp++; if (m_data !== 64'h0 || n_data[31:0] !== 32'h0) begin nerr++; $display("FAIL mid_data: got %h / %h want 0", m_data, n_data[31:0]); end
    ncmp++; if (m_busy !== 2'b00 || n_busy !== 2'b00) begin nerr++; $display("FAIL mid_busy: got %b / %b want 00", m_busy, n_busy); end
  endtask

  initial begin
    test_reset();
    test_conflict();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_range();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port integer register file. Successor to the single-write, two-read register file. Adds configurable width, depth and read-port count, a second write port, optional write-to-read bypass, synchronous clear and a per-register pending scoreboard for multi-cycle writebacks. Sits between decode (read/alloc) and the writeback stages (two write ports: ALU and load/long-latency unit).

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (2..64)
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return the pre-edge value
ZERO_REG, 1, 1 = register 0 hardwired to zero
AW (localparam), $clog2(NREG), address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
RdAddr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW]
RdData  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN]
RdBusy  out  NRD  port i addresses a register with an outstanding producer
WrEn0  in  1  write enable, port 0 (ALU writeback)
WrAddr0  in  AW  write address, port 0
WrData0  in  XLEN  write data, port 0
WrEn1  in  1  write enable, port 1 (load/long-latency writeback)
WrAddr1  in  AW  write address, port 1
WrData1  in  XLEN  write data, port 1
Alloc  in  1  mark AllocAddr pending (producer issued)
AllocAddr  in  AW  register being allocated

Behaviour:
- Reset: on a rising edge with rst=1, all registers clear to 0 and all pending bits clear. rst overrides writes and Alloc in the same cycle. After reset, every RdData reads 0 and every RdBusy reads 0.
- Reads are combinational (zero latency) from the register array, pending bits, and current-cycle write inputs.
- Writes commit at the rising edge.
- Write conflict: if WrEn0 and WrEn1 target the same address, port 1 wins.
- ZERO_REG=1:
  - Writes and Alloc to address 0 are ignored.
  - Reads of address 0 return 0 with RdBusy=0.
- Addresses >= NREG (NREG not a power of two):
  - Writes and Alloc are ignored.
  - Reads return 0 with RdBusy=0.
- BYPASS=1: if a read address matches an enabled, legal write this cycle, RdData is the winning write data (port 1 over port 0) and RdBusy is 0 for that port.
- BYPASS=0: RdData and RdBusy reflect pre-edge state only.
- Scoreboard (one pending bit per register):
  - Alloc=1 sets pending[AllocAddr] at the edge.
  - Any enabled legal write clears pending[WrAddr] at the edge.
  - Alloc and a write to the same address in the same cycle: the pending bit ends set (new producer supersedes), and the data write still commits.
  - Alloc to an already-pending register: the bit stays set (no counting).
- RdBusy[i] = pending[RdAddr_i], subject to the ZERO_REG, range and BYPASS rules above.
- No internal hazard stall: the consumer gates issue on RdBusy.

Test Plan:
- Reset then read: rst=1 for 1 cycle after writing 0xDEADBEEF to r5 -> r5 reads 0x00000000, all RdBusy=0.
- Dual write conflict: WrEn0 r7=0x11111111 and WrEn1 r7=0x22222222 in the same cycle -> next cycle r7=0x22222222. Different addresses (r3, r4) -> both commit.
- Bypass, both settings:
  - BYPASS=1: write r9=0x0000ABCD while RdAddr0=9 -> same-cycle RdData0=0x0000ABCD.
  - BYPASS=0: same stimulus -> old value that cycle, 0x0000ABCD the next.
- Zero register: WrEn0 to r0 with 0xFFFFFFFF, plus Alloc r0 -> r0 reads 0, RdBusy=0.
- Scoreboard:
  - Alloc r12 -> RdBusy=1 while reading r12 on following cycles.
  - WrEn1 r12=0x5 -> busy drops (same cycle if BYPASS=1, next cycle otherwise).
  - Alloc r12 and WrEn0 r12 together -> data updates, busy remains 1.
- Reset mid-operation: r2 pending and WrEn0 r2=0x7 in the rst cycle -> r2=0, not pending, write discarded.
